// File: rtl/fetch_unit.sv
// Fetch stage: owns the architectural PC, issues one instruction-memory request at a
// time over req/ack, and presents the fetched instruction to the fetch/decode register.
module fetch_unit #(
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    INSTR_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 64'h0
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_stall_fetch,
  input  logic                   i_redirect,
  input  logic [DATA_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_imem_req,
  output logic [DATA_WIDTH-1:0]  o_imem_addr,
  input  logic                   i_imem_ack,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0]  o_pc,
  output logic [DATA_WIDTH-1:0]  o_pc_plus4,
  output logic                   o_instr_valid,
  output logic                   o_fetch_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP,
    S_VALID
  } state_t;

  state_t                  state, state_n;
  logic [DATA_WIDTH-1:0]   pc_q, pc_n;
  logic [DATA_WIDTH-1:0]   addr_q, addr_n;
  logic [INSTR_WIDTH-1:0]  instr_q, instr_n;
  logic [DATA_WIDTH-1:0]   opc_q, opc_n;
  logic [DATA_WIDTH-1:0]   opc4_q, opc4_n;
  logic                    valid_q, valid_n;
  logic [DATA_WIDTH-1:0]   target;

  // Instruction fetches are word aligned; low two bits of the target are dropped.
  assign target = i_redirect_pc & ~DATA_WIDTH'(3);

  // NOTE: all sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational block.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state   <= S_IDLE;
      pc_q    <= RESET_VECTOR;
      addr_q  <= RESET_VECTOR;
      instr_q <= '0;
      opc_q   <= '0;
      opc4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      addr_q  <= addr_n;
      instr_q <= instr_n;
      opc_q   <= opc_n;
      opc4_q  <= opc4_n;
      valid_q <= valid_n;
    end
  end

  // NOTE: every variable gets a hold default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    addr_n  = addr_q;
    instr_n = instr_q;
    opc_n   = opc_q;
    opc4_n  = opc4_q;
    valid_n = valid_q;

    unique case (state)
      S_IDLE: begin
        state_n = S_REQ;
        if (i_redirect) begin
          pc_n   = target;
          addr_n = target;
        end else begin
          addr_n = pc_q;
        end
      end

      S_REQ: begin
        if (i_redirect && i_imem_ack) begin
          // The in-flight response has landed; reissue straight at the target.
          pc_n   = target;
          addr_n = target;
        end else if (i_redirect) begin
          pc_n    = target;
          state_n = S_DROP;
        end else if (i_imem_ack) begin
          instr_n = i_imem_rdata;
          opc_n   = addr_q;
          opc4_n  = addr_q + DATA_WIDTH'(4);
          valid_n = 1'b1;
          pc_n    = addr_q + DATA_WIDTH'(4);
          state_n = S_VALID;
        end
      end

      S_DROP: begin
        if (i_redirect) pc_n = target;
        if (i_imem_ack) begin
          addr_n  = i_redirect ? target : pc_q;
          state_n = S_REQ;
        end
      end

      S_VALID: begin
        if (i_redirect) begin
          valid_n = 1'b0;
          pc_n    = target;
          addr_n  = target;
          state_n = S_REQ;
        end else if (!i_stall_fetch) begin
          valid_n = 1'b0;
          addr_n  = pc_q;
          state_n = S_REQ;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign o_imem_req    = (state == S_REQ) || (state == S_DROP);
  assign o_imem_addr   = addr_q;
  assign o_instr       = instr_q;
  assign o_pc          = opc_q;
  assign o_pc_plus4    = opc4_q;
  assign o_instr_valid = valid_q;
  assign o_fetch_busy  = ~valid_q;

endmodule
